// File: rtl/soc_multicore_trace_monitor.sv
//------------------------------------------------------------------------------
// soc_multicore_trace_monitor - multi-core l.nop trace monitor (exit/report/putc, watchdog); optional SOC_TRACE_MONITOR_PERF_EN perf counters. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module soc_multicore_trace_monitor #(
  parameter int          NUM_CORES      = 4,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TERM_CROSS_NUM = NUM_CORES,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [15:0] NOP_EXIT       = 16'h0001,
  parameter logic [15:0] NOP_REPORT     = 16'h0002,
  parameter logic [15:0] NOP_PUTC       = 16'h0004
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CORES-1:0]             trace_valid,
  input  logic [NUM_CORES*32-1:0]          trace_insn,
  input  logic [NUM_CORES-1:0]             trace_wben,
  input  logic [NUM_CORES*5-1:0]           trace_wbreg,
  input  logic [NUM_CORES*32-1:0]          trace_wbdata,
  output logic                             char_valid,
  input  logic                             char_ready,
  output logic [7:0]                       char_data,
  output logic [$clog2(NUM_CORES):0]       char_core,
  output logic                             report_valid,
  output logic [$clog2(NUM_CORES):0]       report_core,
  output logic [31:0]                      report_data,
  output logic [NUM_CORES-1:0]             term_core,
  output logic [31:0]                      exit_code,
  output logic                             done,
  output logic                             timeout,
  output logic                             char_overflow,
  output logic [NUM_CORES*32-1:0]          perf_insn_count
);

  localparam int          IDXW    = $clog2(NUM_CORES) + 1;
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  logic [31:0]          r_shadow [NUM_CORES];
  logic [NUM_CORES-1:0] w_wr3, w_exit_hit, w_rep_hit, w_putc_hit;

  always_comb begin
    w_wr3      = '0;
    w_exit_hit = '0;
    w_rep_hit  = '0;
    w_putc_hit = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_wr3[i] = trace_valid[i] && trace_wben[i] && (trace_wbreg[i*5 +: 5] == 5'd3);
      if (trace_valid[i] && (trace_insn[i*32+16 +: 16] == 16'h1500)) begin
        w_exit_hit[i] = (trace_insn[i*32 +: 16] == NOP_EXIT);
        w_rep_hit[i]  = (trace_insn[i*32 +: 16] == NOP_REPORT);
        w_putc_hit[i] = (trace_insn[i*32 +: 16] == NOP_PUTC);
      end
    end
  end

  // Control nops sample the shadow before this edge's writeback lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (rst)           r_shadow[i] <= '0;
      else if (w_wr3[i]) r_shadow[i] <= trace_wbdata[i*32 +: 32];
    end
  end

  // ---------------- exit / termination ----------------
  logic [31:0] w_first_exit_data;
  int          w_term_cnt;
  logic        w_wd_fire;

  always_comb begin
    w_first_exit_data = '0;
    w_term_cnt        = 0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_exit_hit[i]) w_first_exit_data = r_shadow[i];
      if (term_core[i])  w_term_cnt = w_term_cnt + 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      term_core <= '0;
      exit_code <= '0;
      done      <= 1'b0;
    end else begin
      term_core <= term_core | w_exit_hit;
      if ((term_core == '0) && (|w_exit_hit)) exit_code <= w_first_exit_data;
      if ((w_term_cnt >= TERM_CROSS_NUM) || w_wd_fire) done <= 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  logic [31:0] r_wd_cnt;

  assign w_wd_fire = (TIMEOUT_CYCLES != 0) && !(|trace_valid) && (r_wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
      timeout  <= 1'b0;
    end else if (|trace_valid) begin
      r_wd_cnt <= '0;
    end else if (TIMEOUT_CYCLES != 0) begin
      if (w_wd_fire) timeout  <= 1'b1;
      else           r_wd_cnt <= r_wd_cnt + 32'd1;
    end
  end

  // ---------------- report path ----------------
  logic [NUM_CORES-1:0] r_rep_pend, w_rep_req;
  logic [31:0]          r_rep_data [NUM_CORES];
  logic [IDXW-1:0]      w_rep_sel;
  logic [31:0]          w_rep_sel_data;

  // New reports and queued ones compete together; lowest index wins.
  always_comb begin
    w_rep_req      = r_rep_pend | w_rep_hit;
    w_rep_sel      = '0;
    w_rep_sel_data = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_rep_req[i]) begin
        w_rep_sel      = IDXW'(i);
        w_rep_sel_data = r_rep_pend[i] ? r_rep_data[i] : r_shadow[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_pend   <= '0;
      report_valid <= 1'b0;
      report_core  <= '0;
      report_data  <= '0;
      for (int i = 0; i < NUM_CORES; i++) r_rep_data[i] <= '0;
    end else begin
      report_valid <= |w_rep_req;
      report_core  <= w_rep_sel;
      report_data  <= w_rep_sel_data;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_rep_hit[i] && !r_rep_pend[i]) r_rep_data[i] <= r_shadow[i];
        r_rep_pend[i] <= w_rep_req[i] && (w_rep_sel != IDXW'(i));
      end
    end
  end

  // ---------------- putc slots and round-robin arbiter ----------------
  logic [NUM_CORES-1:0] r_pc_pend;
  logic [7:0]           r_pc_data [NUM_CORES];
  logic [IDXW-1:0]      r_rr_ptr;
  logic [IDXW-1:0]      w_lo_sel, w_hi_sel, w_pc_sel;
  logic [7:0]           w_lo_data, w_hi_data, w_pc_sel_data;
  logic                 w_lo_vld, w_hi_vld, w_push, w_pop, w_empty, w_full;

  // Round robin: first pending at or above the pointer, else lowest pending.
  always_comb begin
    w_lo_sel  = '0;
    w_hi_sel  = '0;
    w_lo_data = '0;
    w_hi_data = '0;
    w_lo_vld  = 1'b0;
    w_hi_vld  = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (r_pc_pend[i]) begin
        w_lo_vld  = 1'b1;
        w_lo_sel  = IDXW'(i);
        w_lo_data = r_pc_data[i];
        if (IDXW'(i) >= r_rr_ptr) begin
          w_hi_vld  = 1'b1;
          w_hi_sel  = IDXW'(i);
          w_hi_data = r_pc_data[i];
        end
      end
    end
    w_pc_sel      = w_hi_vld ? w_hi_sel  : w_lo_sel;
    w_pc_sel_data = w_hi_vld ? w_hi_data : w_lo_data;
    w_push        = w_lo_vld && (!w_full || w_pop);
  end

  // A slot being drained this cycle can take a new byte without overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_pend     <= '0;
      r_rr_ptr      <= '0;
      char_overflow <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) r_pc_data[i] <= '0;
    end else begin
      if (w_push) r_rr_ptr <= (w_pc_sel == IDXW'(NUM_CORES - 1)) ? '0 : w_pc_sel + IDXW'(1);
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_putc_hit[i]) begin
          if (!r_pc_pend[i] || (w_push && (w_pc_sel == IDXW'(i)))) begin
            r_pc_pend[i] <= 1'b1;
            r_pc_data[i] <= r_shadow[i][7:0];
          end else begin
            char_overflow <= 1'b1;
          end
        end else if (w_push && (w_pc_sel == IDXW'(i))) begin
          r_pc_pend[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------- character FIFO ----------------
  logic [7:0]      r_fifo_data [FIFO_DEPTH];
  logic [IDXW-1:0] r_fifo_core [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop      = !w_empty && char_ready;
  assign char_valid = !w_empty;
  assign char_data  = w_empty ? 8'd0 : r_fifo_data[r_rptr];
  assign char_core  = w_empty ? '0   : r_fifo_core[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= w_pc_sel_data;
      r_fifo_core[r_wptr] <= w_pc_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  // ---------------- optional per-core retired-instruction counters ----------------
`ifdef SOC_TRACE_MONITOR_PERF_EN
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_perf
    logic [31:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst)                                       r_cnt <= '0;
      else if (!done && trace_valid[g] && (r_cnt != '1)) r_cnt <= r_cnt + 32'd1;
    end
    assign perf_insn_count[g*32 +: 32] = r_cnt;
  end
`else
  assign perf_insn_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_soc_multicore_trace_monitor.sv
//------------------------------------------------------------------------------
// tb_soc_multicore_trace_monitor - directed self-checking bench (4 cores, TERM_CROSS_NUM=2, TIMEOUT_CYCLES=16). Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_soc_multicore_trace_monitor;

  localparam logic [15:0] K_EXIT   = 16'h0001;
  localparam logic [15:0] K_REPORT = 16'h0002;
  localparam logic [15:0] K_PUTC   = 16'h0004;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   trace_valid, trace_wben;
  logic [127:0] trace_insn, trace_wbdata;
  logic [19:0]  trace_wbreg;
  logic         char_valid, char_ready;
  logic [7:0]   char_data;
  logic [2:0]   char_core, report_core;
  logic         report_valid, done, timeout, char_overflow;
  logic [31:0]  report_data, exit_code;
  logic [3:0]   term_core;
  logic [127:0] perf_insn_count;

  int n_cmp = 0;
  int n_err = 0;

  soc_multicore_trace_monitor #(
    .NUM_CORES(4), .FIFO_DEPTH(8), .TERM_CROSS_NUM(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .trace_valid(trace_valid), .trace_insn(trace_insn), .trace_wben(trace_wben),
    .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
    .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data), .char_core(char_core),
    .report_valid(report_valid), .report_core(report_core), .report_data(report_data),
    .term_core(term_core), .exit_code(exit_code), .done(done), .timeout(timeout),
    .char_overflow(char_overflow), .perf_insn_count(perf_insn_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit: got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    trace_valid  = '0;
    trace_wben   = '0;
    trace_insn   = '0;
    trace_wbreg  = '0;
    trace_wbdata = '0;
  endtask

  task automatic wr3(input int c, input logic [31:0] v);
    trace_valid[c]          = 1'b1;
    trace_wben[c]           = 1'b1;
    trace_wbreg[c*5 +: 5]   = 5'd3;
    trace_wbdata[c*32 +: 32] = v;
    trace_insn[c*32 +: 32]  = 32'hE0632004;
  endtask

  task automatic nop(input int c, input logic [15:0] k);
    trace_valid[c]         = 1'b1;
    trace_insn[c*32 +: 32] = {16'h1500, k};
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    char_ready = 1'b0;
    do_reset();
    n_cmp++;
    if ({char_valid, report_valid, term_core, exit_code, done, timeout, char_overflow,
         char_data, char_core, report_core, report_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got cv=%b rv=%b term=%b exit=%h done=%b to=%b ovf=%b want all 0",
               char_valid, report_valid, term_core, exit_code, done, timeout, char_overflow);
    end
`ifndef SOC_TRACE_MONITOR_PERF_EN
    n_cmp++;
    if (perf_insn_count !== '0) begin
      n_err++;
      $display("FAIL reset_perf: got %h want 0", perf_insn_count);
    end
`endif
  endtask

  task automatic test_putc_single();
    char_ready = 1'b1;
    do_reset();
    wr3(0, 32'h41); tick();
    clr(); nop(0, K_PUTC); tick();
    clr();
    n_cmp++;
    if (char_valid !== 1'b0) begin
      n_err++; $display("FAIL putc_latency1: got char_valid=%b want 0", char_valid);
    end
    tick();
    n_cmp++;
    if ({char_valid, char_data, char_core} !== {1'b1, 8'h41, 3'd0}) begin
      n_err++; $display("FAIL putc_single: got v=%b d=%h c=%0d want v=1 d=41 c=0", char_valid, char_data, char_core);
    end
    tick();
    n_cmp++;
    if (char_valid !== 1'b0) begin
      n_err++; $display("FAIL putc_popped: got char_valid=%b want 0", char_valid);
    end
  endtask

  task automatic test_putc_all_cores();
    logic [7:0] exp_ch [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
    char_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 4; c++) wr3(c, 32'h61 + 32'(c));
    tick();
    clr();
    for (int c = 0; c < 4; c++) nop(c, K_PUTC);
    tick();
    clr();
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({char_valid, char_data, char_core} !== {1'b1, exp_ch[k], 3'(k)}) begin
        n_err++; $display("FAIL putc_rr_order[%0d]: got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                          k, char_valid, char_data, char_core, exp_ch[k], k);
      end
      tick();
    end
    n_cmp++;
    if ({char_valid, char_overflow} !== 2'b00) begin
      n_err++; $display("FAIL putc_rr_tail: got v=%b ovf=%b want 0 0", char_valid, char_overflow);
    end
  endtask

  task automatic test_overflow();
    char_ready = 1'b0;
    do_reset();
    wr3(1, 32'h30); tick();
    for (int k = 0; k < 10; k++) begin
      clr();
      wr3(1, 32'h31 + 32'(k));
      nop(1, K_PUTC);
      tick();
    end
    clr();
    tick();
    n_cmp++;
    if ({char_overflow, char_valid, char_data, char_core} !== {1'b1, 1'b1, 8'h30, 3'd1}) begin
      n_err++; $display("FAIL overflow_state: got ovf=%b v=%b d=%h c=%0d want ovf=1 v=1 d=30 c=1",
                        char_overflow, char_valid, char_data, char_core);
    end
    char_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if ({char_valid, char_data} !== {1'b1, 8'h30 + 8'(k)}) begin
        n_err++; $display("FAIL overflow_drain[%0d]: got v=%b d=%h want v=1 d=%h",
                          k, char_valid, char_data, 8'h30 + 8'(k));
      end
      tick();
    end
    n_cmp++;
    if (char_valid !== 1'b0) begin
      n_err++; $display("FAIL overflow_drain_end: got char_valid=%b want 0", char_valid);
    end
  endtask

  task automatic test_exit();
    char_ready = 1'b1;
    do_reset();
    wr3(2, 32'd7); wr3(0, 32'd3); tick();
    clr(); nop(2, K_EXIT); tick();
    n_cmp++;
    if ({term_core, exit_code, done} !== {4'b0100, 32'd7, 1'b0}) begin
      n_err++; $display("FAIL exit_first: got term=%b code=%0d done=%b want 0100 7 0", term_core, exit_code, done);
    end
    clr(); nop(0, K_EXIT); tick();
    n_cmp++;
    if ({term_core, exit_code, done} !== {4'b0101, 32'd7, 1'b0}) begin
      n_err++; $display("FAIL exit_second: got term=%b code=%0d done=%b want 0101 7 0", term_core, exit_code, done);
    end
    clr(); tick();
    n_cmp++;
    if ({done, timeout} !== 2'b10) begin
      n_err++; $display("FAIL exit_done: got done=%b timeout=%b want 1 0", done, timeout);
    end
  endtask

  task automatic test_report();
    char_ready = 1'b1;
    do_reset();
    wr3(1, 32'h11); wr3(3, 32'h33); tick();
    clr(); nop(1, K_REPORT); nop(3, K_REPORT); tick();
    clr();
    n_cmp++;
    if ({report_valid, report_core, report_data} !== {1'b1, 3'd1, 32'h11}) begin
      n_err++; $display("FAIL report_first: got v=%b c=%0d d=%h want 1 1 11", report_valid, report_core, report_data);
    end
    tick();
    n_cmp++;
    if ({report_valid, report_core, report_data} !== {1'b1, 3'd3, 32'h33}) begin
      n_err++; $display("FAIL report_queued: got v=%b c=%0d d=%h want 1 3 33", report_valid, report_core, report_data);
    end
    tick();
    n_cmp++;
    if (report_valid !== 1'b0) begin
      n_err++; $display("FAIL report_end: got v=%b want 0", report_valid);
    end
  endtask

  task automatic test_timeout();
    char_ready = 1'b1;
    do_reset();
    for (int k = 1; k <= 15; k++) tick();
    n_cmp++;
    if ({timeout, done} !== 2'b00) begin
      n_err++; $display("FAIL timeout_early: got to=%b done=%b want 0 0 at cycle 15", timeout, done);
    end
    tick();
    n_cmp++;
    if ({timeout, done} !== 2'b11) begin
      n_err++; $display("FAIL timeout_fire: got to=%b done=%b want 1 1 at cycle 16", timeout, done);
    end
    do_reset();
    for (int k = 1; k <= 9; k++) tick();
    trace_valid[0] = 1'b1; trace_insn[31:0] = 32'hE0632004; tick();
    clr();
    for (int k = 11; k <= 25; k++) tick();
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_err++; $display("FAIL timeout_delayed_early: got to=%b want 0 at cycle 25", timeout);
    end
    tick();
    n_cmp++;
    if ({timeout, done} !== 2'b11) begin
      n_err++; $display("FAIL timeout_delayed_fire: got to=%b done=%b want 1 1 at cycle 26", timeout, done);
    end
  endtask

  task automatic test_reset_midop();
    char_ready = 1'b0;
    do_reset();
    wr3(0, 32'h50); wr3(1, 32'h51); wr3(2, 32'h52); tick();
    clr(); nop(0, K_PUTC); nop(1, K_PUTC); nop(2, K_PUTC); tick();
    clr(); tick(); tick(); tick();
    nop(0, K_REPORT); nop(1, K_REPORT); nop(2, K_EXIT); tick();
    clr();
    n_cmp++;
    if ({char_valid, report_valid, term_core} !== {1'b1, 1'b1, 4'b0100}) begin
      n_err++; $display("FAIL midop_setup: got cv=%b rv=%b term=%b want 1 1 0100", char_valid, report_valid, term_core);
    end
    rst = 1'b1; tick();
    n_cmp++;
    if ({char_valid, report_valid, term_core, exit_code, done, timeout, char_overflow} !== '0) begin
      n_err++; $display("FAIL midop_reset: got cv=%b rv=%b term=%b exit=%h done=%b to=%b ovf=%b want all 0",
                        char_valid, report_valid, term_core, exit_code, done, timeout, char_overflow);
    end
    rst = 1'b0; tick();
    n_cmp++;
    if ({char_valid, report_valid} !== 2'b00) begin
      n_err++; $display("FAIL midop_after: got cv=%b rv=%b want 0 0", char_valid, report_valid);
    end
  endtask

  initial begin
    clr();
    rst        = 1'b1;
    char_ready = 1'b0;
    test_reset();
    test_putc_single();
    test_putc_all_cores();
    test_overflow();
    test_exit();
    test_report();
    test_timeout();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
